// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// data width, register count, index width and the port-select encoding.
package regfile_wb_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int IDX_W = $clog2(NREG);

  // Identifies a writeback requester; also used as the round-robin pointer value.
  typedef enum logic {
    PORT_LSU = 1'b0,
    PORT_ALU = 1'b1
  } port_sel_e;

  // The port that should be favoured after the given port has been served.
  function automatic port_sel_e other_port(input port_sel_e p);
    return (p == PORT_LSU) ? PORT_ALU : PORT_LSU;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set when a
// write is issued, cleared when that write retires. Register 0 is never busy.
// A set and a clear to the same index on the same edge leave the bit set.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREG = regfile_wb_arbiter_pkg::NREG,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] rd1_idx,
  input  logic [IW-1:0] rd2_idx,
  output logic          busy
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  assign busy_next[0] = 1'b0;

  // Per-bit next state: set has priority over clear.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_bit
      assign busy_next[gi] = (set_en && (set_idx == IW'(gi))) ? 1'b1 :
                             (clr_en && (clr_idx == IW'(gi))) ? 1'b0 :
                             busy_reg[gi];
    end
  endgenerate

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg[rd1_idx] | busy_reg[rd2_idx];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: grants one of the LSU/ALU writeback
// requests per cycle, registers the accepted write (1-cycle latency) and
// keeps a busy scoreboard used to raise a decode hazard.
// Build option: define WB_RR_EN for round-robin arbitration; otherwise the
// LSU has fixed priority over the ALU and no pointer flop exists.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int NREG = regfile_wb_arbiter_pkg::NREG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [$clog2(NREG)-1:0]   alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [$clog2(NREG)-1:0]   lsu_rd,
  input  logic [XLEN-1:0]           lsu_data,
  input  logic                      issue_valid,
  input  logic [$clog2(NREG)-1:0]   issue_rd,
  input  logic [$clog2(NREG)-1:0]   rs1_idx,
  input  logic [$clog2(NREG)-1:0]   rs2_idx,
  output logic                      hazard,
  output logic                      reg_write,
  output logic [$clog2(NREG)-1:0]   Instruction_rd,
  output logic [XLEN-1:0]           write_data_reg_file
);

  localparam int IW = $clog2(NREG);

  logic            grant_lsu;
  logic            grant_alu;
  logic            xfer;
  logic [IW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wr_en_reg;
  logic [IW-1:0]   wr_rd_reg;
  logic [XLEN-1:0] wr_data_reg;

`ifdef WB_RR_EN
  // Holds the port that wins the next contention; reset favours the LSU.
  port_sel_e prio_reg;

  // Round-robin grant: uncontended requests win outright.
  always_comb begin
    grant_lsu = 1'b0;
    grant_alu = 1'b0;
    if (!rst) begin
      if (lsu_valid && alu_valid) begin
        grant_lsu = (prio_reg == PORT_LSU);
        grant_alu = (prio_reg == PORT_ALU);
      end else begin
        grant_lsu = lsu_valid;
        grant_alu = alu_valid;
      end
    end
  end

  // Pointer moves away from whichever port was just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= PORT_LSU;
    end else if (grant_lsu) begin
      prio_reg <= other_port(PORT_LSU);
    end else if (grant_alu) begin
      prio_reg <= other_port(PORT_ALU);
    end
  end
`else
  // Fixed-priority grant: LSU over ALU.
  always_comb begin
    grant_lsu = !rst && lsu_valid;
    grant_alu = !rst && alu_valid && !lsu_valid;
  end
`endif

  assign lsu_ready = grant_lsu;
  assign alu_ready = grant_alu;
  assign xfer      = grant_lsu | grant_alu;
  assign sel_rd    = grant_lsu ? lsu_rd   : alu_rd;
  assign sel_data  = grant_lsu ? lsu_data : alu_data;

  // Register the accepted write; rd 0 is consumed without producing a write,
  // and the index/data hold their last values whenever no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg   <= 1'b0;
      wr_rd_reg   <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= xfer && (sel_rd != '0);
      if (xfer && (sel_rd != '0)) begin
        wr_rd_reg   <= sel_rd;
        wr_data_reg <= sel_data;
      end
    end
  end

  assign reg_write           = wr_en_reg;
  assign Instruction_rd      = wr_rd_reg;
  assign write_data_reg_file = wr_data_reg;

  regfile_scoreboard #(
    .NREG (NREG),
    .IW   (IW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_valid && (issue_rd != '0)),
    .set_idx (issue_rd),
    .clr_en  (wr_en_reg),
    .clr_idx (wr_rd_reg),
    .rd1_idx (rs1_idx),
    .rd2_idx (rs2_idx),
    .busy    (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. A behavioural model tracks the
// expected grants, the pending register write and the busy set; a compare
// process checks every output each cycle, and directed scenarios add literal
// expectations. Honours WB_RR_EN to match the build under test.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1_idx = '0;
  logic [4:0]  rs2_idx = '0;
  logic        hazard;
  logic        reg_write;
  logic [4:0]  Instruction_rd;
  logic [31:0] write_data_reg_file;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .alu_valid           (alu_valid),
    .alu_ready           (alu_ready),
    .alu_rd              (alu_rd),
    .alu_data            (alu_data),
    .lsu_valid           (lsu_valid),
    .lsu_ready           (lsu_ready),
    .lsu_rd              (lsu_rd),
    .lsu_data            (lsu_data),
    .issue_valid         (issue_valid),
    .issue_rd            (issue_rd),
    .rs1_idx             (rs1_idx),
    .rs2_idx             (rs2_idx),
    .hazard              (hazard),
    .reg_write           (reg_write),
    .Instruction_rd      (Instruction_rd),
    .write_data_reg_file (write_data_reg_file)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_live = 1'b0;
  bit        m_en   = 1'b0;
  bit [4:0]  m_rd   = '0;
  bit [31:0] m_data = '0;
  bit [31:0] m_busy = '0;
  bit        m_prio = 1'b0;   // 0: LSU wins the next tie

  function automatic bit g_lsu();
    if (rst) return 1'b0;
    if (lsu_valid && alu_valid) begin
`ifdef WB_RR_EN
      return (m_prio == 1'b0);
`else
      return 1'b1;
`endif
    end
    return lsu_valid;
  endfunction

  function automatic bit g_alu();
    if (rst) return 1'b0;
    if (lsu_valid && alu_valid) return !g_lsu();
    return alu_valid;
  endfunction

  function automatic bit [31:0] busy_after();
    bit [31:0] b = m_busy;
    if (m_en) b[m_rd] = 1'b0;
    if (issue_valid) b[issue_rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live <= 1'b1;
      m_en   <= 1'b0;
      m_rd   <= '0;
      m_data <= '0;
      m_busy <= '0;
      m_prio <= 1'b0;
    end else begin
      m_en <= (g_lsu() || g_alu()) && ((g_lsu() ? lsu_rd : alu_rd) != 5'd0);
      if ((g_lsu() || g_alu()) && ((g_lsu() ? lsu_rd : alu_rd) != 5'd0)) begin
        m_rd   <= g_lsu() ? lsu_rd : alu_rd;
        m_data <= g_lsu() ? lsu_data : alu_data;
      end
      m_busy <= busy_after();
      if (g_lsu()) m_prio <= 1'b1;
      else if (g_alu()) m_prio <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_lsu_ready", {31'd0, lsu_ready}, {31'd0, g_lsu()});
      chk("cmp_alu_ready", {31'd0, alu_ready}, {31'd0, g_alu()});
      chk("cmp_reg_write", {31'd0, reg_write}, {31'd0, m_en});
      chk("cmp_inst_rd",   {27'd0, Instruction_rd}, {27'd0, m_rd});
      chk("cmp_wdata",     write_data_reg_file, m_data);
      chk("cmp_hazard",    {31'd0, hazard}, {31'd0, m_busy[rs1_idx] | m_busy[rs2_idx]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef WB_RR_EN
  bit       exp_l[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit [4:0] exp_rd[4] = '{5'd3, 5'd5, 5'd3, 5'd5};
`else
  bit       exp_l[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit [4:0] exp_rd[4] = '{5'd3, 5'd3, 5'd3, 5'd3};
`endif

  initial begin
    bit gl, ga;

    // Reset with both requesters valid: no readies.
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    rst = 1'b0; lsu_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_inst_rd",   {27'd0, Instruction_rd}, 32'd0);
    chk("rst_wdata",     write_data_reg_file, 32'd0);
    chk("rst_hazard",    {31'd0, hazard}, 32'd0);

    // Contention for four cycles, rd 3 (LSU) vs rd 5 (ALU).
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arb_lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_l[i]});
      chk("arb_alu_ready", {31'd0, alu_ready}, {31'd0, !exp_l[i]});
      if (i > 0) begin
        chk("arb_reg_write", {31'd0, reg_write}, 32'd1);
        chk("arb_inst_rd",   {27'd0, Instruction_rd}, {27'd0, exp_rd[i-1]});
      end
      tick();
    end
    lsu_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    chk("arb_reg_write", {31'd0, reg_write}, 32'd1);
    chk("arb_inst_rd",   {27'd0, Instruction_rd}, {27'd0, exp_rd[3]});

    // Hazard on rd 7 until the ALU writes it back.
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_idx = 5'd7; rs2_idx = 5'd0;
    @(negedge clk);
    chk("h7_before_set", {31'd0, hazard}, 32'd0);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("h7_set", {31'd0, hazard}, 32'd1);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("h7_hold", {31'd0, hazard}, 32'd1);
    end
    tick();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("h7_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("h7_hazard_xfer", {31'd0, hazard}, 32'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("h7_reg_write", {31'd0, reg_write}, 32'd1);
    chk("h7_inst_rd",   {27'd0, Instruction_rd}, 32'd7);
    chk("h7_wdata",     write_data_reg_file, 32'hDEADBEEF);
    chk("h7_hazard_wr", {31'd0, hazard}, 32'd1);
    tick();
    @(negedge clk);
    chk("h7_cleared",   {31'd0, hazard}, 32'd0);
    chk("h7_wr_done",   {31'd0, reg_write}, 32'd0);
    chk("h7_wdata_hold", write_data_reg_file, 32'hDEADBEEF);

    // Set and clear of rd 9 on the same edge: set wins.
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9; rs1_idx = 5'd0; rs2_idx = 5'd9;
    tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    @(negedge clk);
    chk("h9_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("h9_hazard",    {31'd0, hazard}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    chk("h9_reg_write", {31'd0, reg_write}, 32'd1);
    chk("h9_inst_rd",   {27'd0, Instruction_rd}, 32'd9);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("h9_set_wins", {31'd0, hazard}, 32'd1);
    tick();
    lsu_valid = 1'b1;
    tick();
    lsu_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("h9_retired", {31'd0, hazard}, 32'd0);

    // ALU write to rd 0: accepted, no register write, no hazard.
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    rs1_idx = 5'd0; rs2_idx = 5'd0;
    @(negedge clk);
    chk("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("r0_hazard",    {31'd0, hazard}, 32'd0);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("r0_reg_write", {31'd0, reg_write}, 32'd0);
    chk("r0_rd_hold",   {27'd0, Instruction_rd}, 32'd9);
    chk("r0_wdata_hold", write_data_reg_file, 32'h99);

    // Reset in the cycle after an LSU transfer.
    tick();
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    rs1_idx = 5'd12; rs2_idx = 5'd4;
    @(negedge clk);
    chk("mr_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("mr_hazard",    {31'd0, hazard}, 32'd1);
    tick();
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    @(negedge clk);
    chk("mr_rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    chk("mr_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    rst = 1'b0; lsu_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    chk("mr_reg_write", {31'd0, reg_write}, 32'd0);
    chk("mr_hazard_clr", {31'd0, hazard}, 32'd0);
    chk("mr_inst_rd",   {27'd0, Instruction_rd}, 32'd0);

    // Mixed traffic; each requester holds its request until granted.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      gl = lsu_ready;
      ga = alu_ready;
      tick();
      if (!lsu_valid || gl) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = 5'($urandom_range(0, 31));
        lsu_data  = $urandom;
      end
      if (!alu_valid || ga) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1_idx     = 5'($urandom_range(0, 31));
      rs2_idx     = 5'($urandom_range(0, 31));
    end
    tick();
    lsu_valid = 1'b0; alu_valid = 1'b0; issue_valid = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
